spi_slave_burst: RTL and testbench



---
 rtl/spi_slave_burst.sv | 185 ++++++++++++++++++
 tb/tb_spi_slave_burst.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_burst.sv
// SPI slave with a one-word TX holding register and an RX FIFO, supporting back-to-back multi-word bursts.
// Optional macro SPI_SLAVE_MISO_TRISTATE_EN: release miso (1'bz) while cs_n is high.
module spi_slave_burst #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           RX_DEPTH   = 4,
    parameter bit                    MSB_FIRST  = 1'b1,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '0
) (
    input  logic                  sclk,
    input  logic                  reset,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  tx_underrun,
    output logic                  rx_overflow,
    output logic                  frame_abort
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam int unsigned AW    = $clog2(RX_DEPTH);
    localparam int unsigned OCC_W = AW + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] hold_data_q;
    logic                  hold_full_q;
    logic                  tx_underrun_q, frame_abort_q, rx_overflow_q;

    logic [DATA_WIDTH-1:0] mem [RX_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]      occ_q;

    logic                  shift_en, tx_take, load_src, push, abort_d;
    logic                  tx_load, consume, underrun_d;
    logic                  fifo_full, pop, push_ok, overflow_d;
    logic [DATA_WIDTH-1:0] rx_word_c, tx_src_c, tx_shifted_c;
    logic                  miso_bit;

    // Serial datapath views: assembled RX word including the current mosi bit, shifted TX word.
    always_comb begin
        if (MSB_FIRST) begin
            rx_word_c    = {rx_shift_q[DATA_WIDTH-2:0], mosi};
            tx_shifted_c = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            miso_bit     = tx_shift_q[DATA_WIDTH-1];
        end else begin
            rx_word_c    = {mosi, rx_shift_q[DATA_WIDTH-1:1]};
            tx_shifted_c = {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
            miso_bit     = tx_shift_q[0];
        end
        tx_src_c = hold_full_q ? hold_data_q : FILL_WORD;
    end

    // Next-state and per-edge control.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_en  = 1'b0;
        tx_take   = 1'b0;
        load_src  = 1'b0;
        push      = 1'b0;
        abort_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_n) begin
                    load_src  = 1'b1;
                    bit_cnt_d = '0;
                end else begin
                    state_d   = SHIFT;
                    shift_en  = 1'b1;
                    tx_take   = 1'b1;
                    bit_cnt_d = CNT_W'(1);
                end
            end
            SHIFT: begin
                if (cs_n) begin
                    state_d   = IDLE;
                    load_src  = 1'b1;
                    bit_cnt_d = '0;
                    abort_d   = (bit_cnt_q != '0);
                end else begin
                    shift_en = 1'b1;
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        push      = 1'b1;
                        tx_take   = 1'b1;
                        load_src  = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_src)      tx_shift_d = tx_src_c;
        else if (shift_en) tx_shift_d = tx_shifted_c;
        else               tx_shift_d = tx_shift_q;
        rx_shift_d = shift_en ? rx_word_c : rx_shift_q;

        tx_load    = tx_valid && !hold_full_q;
        consume    = tx_take && hold_full_q;
        underrun_d = tx_take && !hold_full_q;

        fifo_full  = (occ_q == OCC_W'(RX_DEPTH));
        pop        = (occ_q != '0) && rx_ready;
        push_ok    = push && (!fifo_full || pop);
        overflow_d = push && fifo_full && !pop;
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            tx_shift_q    <= FILL_WORD;
            rx_shift_q    <= '0;
            tx_underrun_q <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            tx_underrun_q <= underrun_d;
            frame_abort_q <= abort_d;
        end
    end

    // TX holding register; a load takes precedence over a consume on the same edge.
    always_ff @(posedge sclk) begin
        if (reset) begin
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
        end else if (tx_load) begin
            hold_full_q <= 1'b1;
            hold_data_q <= tx_data;
        end else if (consume) begin
            hold_full_q <= 1'b0;
        end
    end

    // RX FIFO with sticky overflow.
    always_ff @(posedge sclk) begin
        if (reset) begin
            for (int i = 0; i < int'(RX_DEPTH); i++) mem[i] <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            occ_q         <= '0;
            rx_overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr_q] <= rx_word_c;
                wr_ptr_q      <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_ok && !pop)      occ_q <= occ_q + OCC_W'(1);
            else if (pop && !push_ok) occ_q <= occ_q - OCC_W'(1);
            if (overflow_d) rx_overflow_q <= 1'b1;
        end
    end

    assign tx_ready    = !hold_full_q;
    assign rx_valid    = (occ_q != '0);
    assign rx_data     = mem[rd_ptr_q];
    assign tx_underrun = tx_underrun_q;
    assign rx_overflow = rx_overflow_q;
    assign frame_abort = frame_abort_q;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign miso = cs_n ? 1'bz : miso_bit;
`else
    assign miso = miso_bit;
`endif

endmodule

// File: tb/tb_spi_slave_burst.sv
// Directed bench: instance a uses defaults (MSB first, fill 0), instance b is LSB first with fill 8'hFF.
module tb_spi_slave_burst;

    logic       sclk = 1'b0;
    logic       reset, cs_n, mosi, tx_valid, rx_ready;
    logic [7:0] tx_data;

    logic       a_miso, a_tx_ready, a_rx_valid, a_tx_underrun, a_rx_overflow, a_frame_abort;
    logic [7:0] a_rx_data;
    logic       b_miso, b_tx_ready, b_rx_valid, b_tx_underrun, b_rx_overflow, b_frame_abort;
    logic [7:0] b_rx_data;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] ao, bo, au, bu;

    spi_slave_burst u_a (
        .sclk(sclk), .reset(reset), .cs_n(cs_n), .mosi(mosi), .miso(a_miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(a_tx_ready),
        .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(rx_ready),
        .tx_underrun(a_tx_underrun), .rx_overflow(a_rx_overflow), .frame_abort(a_frame_abort)
    );

    spi_slave_burst #(.DATA_WIDTH(8), .RX_DEPTH(4), .MSB_FIRST(1'b0), .FILL_WORD(8'hFF)) u_b (
        .sclk(sclk), .reset(reset), .cs_n(cs_n), .mosi(mosi), .miso(b_miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(b_tx_ready),
        .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(rx_ready),
        .tx_underrun(b_tx_underrun), .rx_overflow(b_rx_overflow), .frame_abort(b_frame_abort)
    );

    always #5 sclk = ~sclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; cs_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; rx_ready = 1'b0; tx_data = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic load_tx(input logic [7:0] d);
        tx_data = d; tx_valid = 1'b1; cs_n = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
    endtask

    task automatic pop_rx();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic end_frame();
        cs_n = 1'b1;
        tick();
    endtask

    // Drives nbits of w (MSB or LSB first); collects miso of both instances and per-edge underrun flags.
    task automatic send_word(input logic [7:0] w, input bit msb, input int nbits,
                             input bit ld, input logic [7:0] nxt,
                             output logic [7:0] a_out, output logic [7:0] b_out,
                             output logic [7:0] a_und, output logic [7:0] b_und);
        a_out = '0; b_out = '0; a_und = '0; b_und = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = msb ? w[3'(7 - i)] : w[3'(i)];
            cs_n = 1'b0;
            if (ld && i == 1) begin
                tx_data = nxt; tx_valid = 1'b1;
            end else begin
                tx_valid = 1'b0;
            end
            a_out[3'(7 - i)] = a_miso;
            b_out[3'(i)]     = b_miso;
            tick();
            a_und[3'(i)] = a_tx_underrun;
            b_und[3'(i)] = b_tx_underrun;
        end
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (a_tx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_tx_ready: got %b want 1", a_tx_ready); end
        vectors++; if (a_rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid: got %b want 0", a_rx_valid); end
        vectors++; if (a_rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data: got %h want 00", a_rx_data); end
        vectors++; if ({a_tx_underrun, a_rx_overflow, a_frame_abort} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b want 000", {a_tx_underrun, a_rx_overflow, a_frame_abort}); end
        vectors++; if (a_miso !== 1'b0) begin miscompares++; $display("FAIL reset_miso_a: got %b want 0", a_miso); end
        vectors++; if (b_miso !== 1'b1) begin miscompares++; $display("FAIL reset_miso_b: got %b want 1", b_miso); end
    endtask

    task automatic test_single();
        do_reset();
        load_tx(8'hD4);
        send_word(8'hAA, 1'b1, 8, 1'b0, 8'h00, ao, bo, au, bu);
        vectors++; if (ao !== 8'hD4) begin miscompares++; $display("FAIL single_miso: got %h want d4", ao); end
        vectors++; if (au !== 8'h80) begin miscompares++; $display("FAIL single_underrun: got %h want 80", au); end
        end_frame();
        vectors++; if (a_frame_abort !== 1'b0) begin miscompares++; $display("FAIL single_abort: got %b want 0", a_frame_abort); end
        vectors++; if (a_rx_valid !== 1'b1) begin miscompares++; $display("FAIL single_rx_valid: got %b want 1", a_rx_valid); end
        vectors++; if (a_rx_data !== 8'hAA) begin miscompares++; $display("FAIL single_rx_data: got %h want aa", a_rx_data); end
    endtask

    task automatic test_burst();
        do_reset();
        load_tx(8'h3C);
        send_word(8'h12, 1'b1, 8, 1'b1, 8'hF0, ao, bo, au, bu);
        vectors++; if (ao !== 8'h3C) begin miscompares++; $display("FAIL burst_miso0: got %h want 3c", ao); end
        vectors++; if (au !== 8'h00) begin miscompares++; $display("FAIL burst_underrun0: got %h want 00", au); end
        send_word(8'h34, 1'b1, 8, 1'b0, 8'h00, ao, bo, au, bu);
        vectors++; if (ao !== 8'hF0) begin miscompares++; $display("FAIL burst_miso1: got %h want f0", ao); end
        vectors++; if (a_tx_ready !== 1'b1) begin miscompares++; $display("FAIL burst_tx_ready: got %b want 1", a_tx_ready); end
        end_frame();
        vectors++; if (a_rx_data !== 8'h12) begin miscompares++; $display("FAIL burst_rx0: got %h want 12", a_rx_data); end
        pop_rx();
        vectors++; if (a_rx_data !== 8'h34) begin miscompares++; $display("FAIL burst_rx1: got %h want 34", a_rx_data); end
        pop_rx();
        vectors++; if (a_rx_valid !== 1'b0) begin miscompares++; $display("FAIL burst_empty: got %b want 0", a_rx_valid); end
    endtask

    task automatic test_underrun();
        do_reset();
        send_word(8'h00, 1'b0, 8, 1'b0, 8'h00, ao, bo, au, bu);
        vectors++; if (bu !== 8'h81) begin miscompares++; $display("FAIL underrun_pulses: got %h want 81", bu); end
        vectors++; if (bo !== 8'hFF) begin miscompares++; $display("FAIL underrun_miso: got %h want ff", bo); end
        end_frame();
    endtask

    task automatic test_overflow();
        logic [7:0] words [5];
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        do_reset();
        for (int k = 0; k < 4; k++) send_word(words[k], 1'b1, 8, 1'b0, 8'h00, ao, bo, au, bu);
        vectors++; if (a_rx_overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_early: got %b want 0", a_rx_overflow); end
        send_word(words[4], 1'b1, 8, 1'b0, 8'h00, ao, bo, au, bu);
        vectors++; if (a_rx_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b want 1", a_rx_overflow); end
        end_frame();
        tick();
        vectors++; if (a_rx_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", a_rx_overflow); end
        for (int k = 0; k < 4; k++) begin
            vectors++; if (a_rx_data !== words[k]) begin miscompares++; $display("FAIL ovf_word%0d: got %h want %h", k, a_rx_data, words[k]); end
            pop_rx();
        end
        vectors++; if (a_rx_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_empty: got %b want 0", a_rx_valid); end
        vectors++; if (a_rx_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_after_pop: got %b want 1", a_rx_overflow); end
    endtask

    task automatic test_abort();
        do_reset();
        send_word(8'h5A, 1'b1, 8, 1'b0, 8'h00, ao, bo, au, bu);
        send_word(8'hE0, 1'b1, 3, 1'b0, 8'h00, ao, bo, au, bu);
        end_frame();
        vectors++; if (a_frame_abort !== 1'b1) begin miscompares++; $display("FAIL abort_pulse: got %b want 1", a_frame_abort); end
        tick();
        vectors++; if (a_frame_abort !== 1'b0) begin miscompares++; $display("FAIL abort_once: got %b want 0", a_frame_abort); end
        send_word(8'hA5, 1'b1, 8, 1'b0, 8'h00, ao, bo, au, bu);
        end_frame();
        vectors++; if (a_rx_data !== 8'h5A) begin miscompares++; $display("FAIL abort_fifo0: got %h want 5a", a_rx_data); end
        pop_rx();
        vectors++; if (a_rx_data !== 8'hA5) begin miscompares++; $display("FAIL abort_realign: got %h want a5", a_rx_data); end
        pop_rx();
        vectors++; if (a_rx_valid !== 1'b0) begin miscompares++; $display("FAIL abort_empty: got %b want 0", a_rx_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        load_tx(8'h77);
        send_word(8'h0F, 1'b1, 8, 1'b0, 8'h00, ao, bo, au, bu);
        send_word(8'hC3, 1'b1, 4, 1'b0, 8'h00, ao, bo, au, bu);
        tx_data = 8'h99; tx_valid = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0; tx_valid = 1'b0; cs_n = 1'b1;
        vectors++; if ({a_tx_ready, a_rx_valid} !== 2'b10) begin miscompares++; $display("FAIL rstmid_hs: got %b want 10", {a_tx_ready, a_rx_valid}); end
        vectors++; if (a_rx_data !== 8'h00) begin miscompares++; $display("FAIL rstmid_rx_data: got %h want 00", a_rx_data); end
        vectors++; if ({a_tx_underrun, a_rx_overflow, a_frame_abort, a_miso} !== 4'b0000) begin miscompares++; $display("FAIL rstmid_flags: got %b want 0000", {a_tx_underrun, a_rx_overflow, a_frame_abort, a_miso}); end
        tick();
        vectors++; if (a_frame_abort !== 1'b0) begin miscompares++; $display("FAIL rstmid_no_abort: got %b want 0", a_frame_abort); end
    endtask

    task automatic test_lsb_first();
        do_reset();
        load_tx(8'h01);
        send_word(8'hAA, 1'b0, 8, 1'b0, 8'h00, ao, bo, au, bu);
        vectors++; if (bo !== 8'h01) begin miscompares++; $display("FAIL lsb_miso: got %h want 01", bo); end
        end_frame();
        vectors++; if (b_rx_valid !== 1'b1) begin miscompares++; $display("FAIL lsb_rx_valid: got %b want 1", b_rx_valid); end
        vectors++; if (b_rx_data !== 8'hAA) begin miscompares++; $display("FAIL lsb_rx_data: got %h want aa", b_rx_data); end
    endtask

    initial begin
        reset = 1'b1; cs_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; rx_ready = 1'b0; tx_data = '0;
        test_reset();
        test_single();
        test_burst();
        test_underrun();
        test_overflow();
        test_abort();
        test_reset_mid();
        test_lsb_first();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
